// File: rtl/imm_data_gen_if.sv
// imm_data_gen_if
//   Bundles the immediate generator's data path signals.
//   instruction : 32-bit instruction word from instruction memory
//   ImmSrc      : 2-bit immediate format select from the control unit
//   imm_data    : 32-bit registered, sign-extended immediate
//   master modport drives instruction/ImmSrc and reads imm_data;
//   slave modport is the generator side.
interface imm_data_gen_if;
  logic [31:0] instruction;
  logic [1:0]  ImmSrc;
  logic [31:0] imm_data;

  modport master (
    output instruction,
    output ImmSrc,
    input  imm_data
  );

  modport slave (
    input  instruction,
    input  ImmSrc,
    output imm_data
  );
endinterface

// File: rtl/imm_data_gen.sv
// imm_data_gen
//   Immediate generator for the single-cycle RV32I datapath. Selects the
//   immediate field of the current instruction by ImmSrc, sign-extends it
//   to 32 bits and registers it (1-cycle latency, new result every cycle).
//   Ports:
//     clk   : system clock, rising-edge active
//     reset : synchronous, active-high; clears imm_data to zero
//     bus   : imm_data_gen_if.slave (instruction, ImmSrc in; imm_data out)
module imm_data_gen (
  input logic          clk,
  input logic          reset,
  imm_data_gen_if.slave bus
);

  logic [31:0] imm_next;

  // Format decode. B and J immediates are produced as halfword offsets:
  // the ISA offset's always-zero bit 0 is dropped rather than kept, so the
  // fields start at instruction[11:8] / instruction[30:21] for the LSBs.
  always_comb begin
    imm_next = 32'h0000_0000;
    case (bus.ImmSrc)
      2'b00: imm_next = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
      2'b01: imm_next = {{20{bus.instruction[31]}}, bus.instruction[31:25],
                         bus.instruction[11:7]};
      2'b10: imm_next = {{20{bus.instruction[31]}}, bus.instruction[31],
                         bus.instruction[7], bus.instruction[30:25],
                         bus.instruction[11:8]};
      2'b11: imm_next = {{12{bus.instruction[31]}}, bus.instruction[31],
                         bus.instruction[19:12], bus.instruction[20],
                         bus.instruction[30:21]};
    endcase
  end

  // Output register; reset wins over the decoded value.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.imm_data <= 32'h0000_0000;
    end else begin
      bus.imm_data <= imm_next;
    end
  end

endmodule

// File: tb/tb_imm_data_gen.sv
// tb_imm_data_gen
//   Self-checking bench for imm_data_gen. Directed vectors per format plus
//   randomized traffic, compared against an arithmetic reference model that
//   rebuilds the ISA offset and scales it to the emitted form.
module tb_imm_data_gen;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  imm_data_gen_if bus ();

  imm_data_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: compute the signed immediate value numerically from the
  // instruction fields, then halve B/J offsets (which are always even).
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] src);
    int off;
    off = 0;
    case (src)
      2'd0: off = $signed(ins) >>> 20;
      2'd1: off = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
      2'd2: begin
        off = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
            + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        off = off / 2;
      end
      2'd3: begin
        off = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
            + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        off = off / 2;
      end
    endcase
    return off;
  endfunction

  // Drive one vector, let one rising edge pass, sample 1 time unit later.
  task automatic apply(input logic [31:0] ins, input logic [1:0] src);
    bus.instruction = ins;
    bus.ImmSrc      = src;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] expected);
    vectors++;
    if (bus.imm_data !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, bus.imm_data, expected);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(32'hFFFF_FFFF, 2'(i + 2));
      check("reset", 32'h0000_0000);
    end
    reset = 1'b0;
  endtask

  task automatic test_itype();
    apply(32'h1A30_0000, 2'b00); check("itype_pos", 32'h0000_01A3);
    apply(32'hEC40_0000, 2'b00); check("itype_neg", 32'hFFFF_FEC4);
  endtask

  task automatic test_stype();
    apply(32'h6940_0A80, 2'b01); check("stype_pos", 32'h0000_0695);
    apply(32'hF9F0_0FC0, 2'b01); check("stype_neg", 32'hFFFF_FF9F);
  endtask

  task automatic test_btype();
    apply(32'h34B5_A080, 2'b10); check("btype_pos", 32'h0000_05A0);
    apply(32'hFFFE_0F00, 2'b10); check("btype_neg", 32'hFFFF_FBFF);
  endtask

  task automatic test_jtype();
    apply(32'h0010_0000, 2'b11); check("jtype_pos", 32'h0000_0400);
    apply(32'h8000_0000, 2'b11); check("jtype_neg", 32'hFFF8_0000);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [1:0]  src;
    for (int i = 0; i < 200; i++) begin
      ins = $urandom;
      src = 2'($urandom_range(0, 3));
      apply(ins, src);
      check("random", ref_imm(ins, src));
      if (ins[31] && bus.imm_data[31] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL sign_msb: got %b, expected 1", bus.imm_data[31]);
      end
    end
  endtask

  // Inputs change every cycle; a one-cycle reset lands mid-stream and the
  // stream must resume with the very next vector.
  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [1:0]  src;
    for (int i = 0; i < 40; i++) begin
      ins   = $urandom;
      src   = 2'(i % 4);
      reset = (i == 20);
      apply(ins, src);
      if (i == 20) check("b2b_reset", 32'h0000_0000);
      else         check("b2b", ref_imm(ins, src));
    end
    reset = 1'b0;
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    bus.instruction = 32'hFFFF_FFFF;
    bus.ImmSrc      = 2'b00;
    #1;
    test_reset();
    test_itype();
    test_stype();
    test_btype();
    test_jtype();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
